fetch_mem_responder: RTL and testbench

Memory-side responder for the instruction fetch path.
- Holds the byte-addressed program memory and answers fetch read requests with a 16-bit little-endian instruction word: {mem[a+1], mem[a]}.
- Uses a fixed, parameterised access latency and a valid/ready handshake on both the request and response sides.
- Provides a byte-wide load port so the testbench or boot loader can write program bytes before and during execution.

---
 rtl/fetch_mem_responder_pkg.sv | 23 ++
 rtl/fetch_mem_responder_byte_ram.sv | 43 ++++
 rtl/fetch_mem_responder.sv | 120 ++++++++++++
 tb/tb_fetch_mem_responder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_mem_responder_pkg.sv
// fetch_mem_responder_pkg: constants and types shared by the
// fetch path (FSM states, memory size, instruction width, PC reset).
package fetch_mem_responder_pkg;

   localparam int unsigned MEM_SIZE_DEF = 65536;
   localparam int unsigned INSTR_W      = 16;
   localparam logic [15:0] PC_RESET     = 16'h0064;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } fetch_state_t;

   // True when both bytes a and a+1 lie inside a memory of size bytes.
   function automatic logic fetch_in_range(
      input logic [31:0] a,
      input int unsigned size
   );
      return a <= (size - 32'd2);
   endfunction

endpackage

// File: rtl/fetch_mem_responder_byte_ram.sv
// byte_ram: byte-wide program memory, one synchronous write port
// and two combinational read ports. Out-of-range accesses are inert.
//   clk          rising-edge clock
//   we/wa/wd     byte write strobe, address, data
//   ra_a/rd_a    read port A address/data
//   ra_b/rd_b    read port B address/data
module byte_ram #(
   parameter int DEPTH = 65536,
   parameter int AW    = 16
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] wa,
   input  logic [7:0]    wd,
   input  logic [AW-1:0] ra_a,
   output logic [7:0]    rd_a,
   input  logic [AW-1:0] ra_b,
   output logic [7:0]    rd_b
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [7:0] mem [DEPTH];

   logic wa_ok;
   logic ra_ok;
   logic rb_ok;

   assign wa_ok = 32'(wa) < DEPTH;
   assign ra_ok = 32'(ra_a) < DEPTH;
   assign rb_ok = 32'(ra_b) < DEPTH;

   // No reset: program contents survive rst.
   always_ff @(posedge clk) begin
      if (we && wa_ok) begin
         mem[wa[IW-1:0]] <= wd;
      end
   end

   assign rd_a = ra_ok ? mem[ra_a[IW-1:0]] : 8'h00;
   assign rd_b = rb_ok ? mem[ra_b[IW-1:0]] : 8'h00;

endmodule

// File: rtl/fetch_mem_responder.sv
// fetch_mem_responder: answers fetch reads with {mem[a+1], mem[a]}
// after a fixed latency; valid/ready on request and response.
//   clk, rst                 clock; async active-high reset
//   req_valid/ready/addr     fetch request handshake
//   rsp_valid/ready/data/err fetch response handshake
//   ld_en/addr/data          byte load port, any state
//   busy                     transaction in flight
module fetch_mem_responder
   import fetch_mem_responder_pkg::*;
#(
   parameter int MEM_SIZE     = int'(MEM_SIZE_DEF),
   parameter int ADDR_W       = 16,
   parameter int READ_LATENCY = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [ADDR_W-1:0]  req_addr,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [INSTR_W-1:0] rsp_data,
   output logic               rsp_err,
   input  logic               ld_en,
   input  logic [ADDR_W-1:0]  ld_addr,
   input  logic [7:0]         ld_data,
   output logic               busy
);

   localparam int CNT_W =
      (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam logic [CNT_W-1:0] LAT_M1 =
      CNT_W'(READ_LATENCY - 1);

   fetch_state_t      state;
   logic [CNT_W-1:0]  cnt;
   logic [ADDR_W-1:0] addr_q;

   logic [ADDR_W-1:0] rd_addr;
   logic [ADDR_W-1:0] rd_addr_hi;
   logic [7:0]        rd_lo;
   logic [7:0]        rd_hi;
   logic              err_now;
   logic [15:0]       word_now;

   // In IDLE the live request address feeds the RAM so a
   // single-cycle latency can sample on the accept edge.
   assign rd_addr    = (state == IDLE) ? req_addr : addr_q;
   assign rd_addr_hi = rd_addr + 1'b1;
   assign err_now    = !fetch_in_range(32'(rd_addr), MEM_SIZE);
   assign word_now   = err_now ? 16'h0000 : {rd_hi, rd_lo};

   byte_ram #(
      .DEPTH (MEM_SIZE),
      .AW    (ADDR_W)
   ) u_ram (
      .clk  (clk),
      .we   (ld_en),
      .wa   (ld_addr),
      .wd   (ld_data),
      .ra_a (rd_addr),
      .rd_a (rd_lo),
      .ra_b (rd_addr_hi),
      .rd_b (rd_hi)
   );

   assign req_ready = (state == IDLE) && !rst;
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         addr_q    <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (req_valid) begin
                  addr_q <= req_addr;
                  if (READ_LATENCY == 1) begin
                     rsp_data  <= word_now;
                     rsp_err   <= err_now;
                     rsp_valid <= 1'b1;
                     state     <= RESP;
                  end else begin
                     cnt   <= LAT_M1;
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               // RAM read is combinational, so a write landing on
               // this same edge is not seen (read-before-write).
               if (cnt == '0) begin
                  rsp_data  <= word_now;
                  rsp_err   <= err_now;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               rsp_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_mem_responder.sv
// tb_fetch_mem_responder: directed self-checking bench for the
// fetch memory responder (latency, backpressure, range, collisions).
module tb_fetch_mem_responder;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [15:0] req_addr;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_data;
   logic        rsp_err;
   logic        ld_en;
   logic [15:0] ld_addr;
   logic [7:0]  ld_data;
   logic        busy;

   int checks;
   int failures;

   fetch_mem_responder #(
      .MEM_SIZE     (65536),
      .ADDR_W       (16),
      .READ_LATENCY (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .ld_en     (ld_en),
      .ld_addr   (ld_addr),
      .ld_data   (ld_data),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs,
                       input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk16(input string tag, input logic [15:0] obs,
                        input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic load(input logic [15:0] a, input logic [7:0] d);
      ld_en   = 1'b1;
      ld_addr = a;
      ld_data = d;
      tick();
      ld_en   = 1'b0;
   endtask

   // Full transaction with 2-cycle latency checks and immediate accept.
   task automatic fetch(input logic [15:0] a, input logic [15:0] ed,
                        input logic ee, input string tag);
      req_valid = 1'b1;
      req_addr  = a;
      chk1({tag, ".req_ready"}, req_ready, 1'b1);
      tick();
      req_valid = 1'b0;
      chk1({tag, ".busy"}, busy, 1'b1);
      chk1({tag, ".valid_c0"}, rsp_valid, 1'b0);
      tick();
      chk1({tag, ".valid_c1"}, rsp_valid, 1'b0);
      tick();
      chk1({tag, ".valid_c2"}, rsp_valid, 1'b1);
      chk16({tag, ".data"}, rsp_data, ed);
      chk1({tag, ".err"}, rsp_err, ee);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk1({tag, ".valid_done"}, rsp_valid, 1'b0);
      chk1({tag, ".idle"}, busy, 1'b0);
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      rst       = 1'b0;
      req_valid = 1'b0;
      req_addr  = 16'h0000;
      rsp_ready = 1'b0;
      ld_en     = 1'b0;
      ld_addr   = 16'h0000;
      ld_data   = 8'h00;

      // Reset state
      #2 rst = 1'b1;
      #1;
      chk1("rst.req_ready", req_ready, 1'b0);
      chk1("rst.rsp_valid", rsp_valid, 1'b0);
      chk1("rst.busy", busy, 1'b0);
      chk16("rst.rsp_data", rsp_data, 16'h0000);
      chk1("rst.rsp_err", rsp_err, 1'b0);
      tick();
      chk1("rst.req_ready_clk", req_ready, 1'b0);
      rst = 1'b0;
      #1;
      chk1("post_rst.req_ready", req_ready, 1'b1);

      // Basic aligned fetch
      load(16'h0064, 8'h34);
      load(16'h0065, 8'h12);
      fetch(16'h0064, 16'h1234, 1'b0, "basic");

      // Odd address
      load(16'h0066, 8'h56);
      fetch(16'h0065, 16'h5612, 1'b0, "odd");

      // Backpressure; a stray request in RESP must be ignored
      req_valid = 1'b1;
      req_addr  = 16'h0064;
      tick();
      req_valid = 1'b0;
      tick();
      tick();
      chk1("bp.valid_c2", rsp_valid, 1'b1);
      req_valid = 1'b1;
      req_addr  = 16'h0065;
      for (int i = 0; i < 3; i++) begin
         chk1("bp.valid", rsp_valid, 1'b1);
         chk16("bp.data", rsp_data, 16'h1234);
         chk1("bp.req_ready", req_ready, 1'b0);
         chk1("bp.busy", busy, 1'b1);
         tick();
      end
      req_valid = 1'b0;
      chk16("bp.data_end", rsp_data, 16'h1234);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk1("bp.idle", busy, 1'b0);
      chk1("bp.req_ready_idle", req_ready, 1'b1);
      chk1("bp.valid_low", rsp_valid, 1'b0);

      // Range boundary
      fetch(16'hFFFF, 16'h0000, 1'b1, "range_ffff");
      load(16'hFFFE, 8'hCD);
      load(16'hFFFF, 8'hEF);
      fetch(16'hFFFE, 16'hEFCD, 1'b0, "range_fffe");
      fetch(16'hFFFF, 16'h0000, 1'b1, "range_ffff2");

      // Collision: write on first WAIT edge is visible
      req_valid = 1'b1;
      req_addr  = 16'h0064;
      tick();
      req_valid = 1'b0;
      ld_en   = 1'b1;
      ld_addr = 16'h0065;
      ld_data = 8'hAB;
      tick();
      ld_en = 1'b0;
      tick();
      chk1("col1.valid", rsp_valid, 1'b1);
      chk16("col1.data", rsp_data, 16'hAB34);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      load(16'h0065, 8'h12);

      // Collision: write on the sample edge is not visible
      req_valid = 1'b1;
      req_addr  = 16'h0064;
      tick();
      req_valid = 1'b0;
      tick();
      ld_en   = 1'b1;
      ld_addr = 16'h0065;
      ld_data = 8'hAB;
      tick();
      ld_en = 1'b0;
      chk1("col2.valid", rsp_valid, 1'b1);
      chk16("col2.data", rsp_data, 16'h1234);
      // Write while in RESP leaves held data alone
      load(16'h0065, 8'h77);
      chk16("col3.held", rsp_data, 16'h1234);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      fetch(16'h0064, 16'h7734, 1'b0, "col_after");
      load(16'h0065, 8'h12);

      // Reset during WAIT drops the transaction
      req_valid = 1'b1;
      req_addr  = 16'h0064;
      tick();
      req_valid = 1'b0;
      chk1("rw.busy", busy, 1'b1);
      rst = 1'b1;
      #1;
      chk1("rw.busy_rst", busy, 1'b0);
      chk1("rw.req_ready_rst", req_ready, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk1("rw.valid_in_rst", rsp_valid, 1'b0);
      end
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk1("rw.valid_after", rsp_valid, 1'b0);
         chk1("rw.req_ready_after", req_ready, 1'b1);
      end
      fetch(16'h0064, 16'h1234, 1'b0, "rw_fresh");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
